// File: rtl/cpu_ex_mdu_if.sv
// Decode <-> execute-stage bus for cpu_ex_mdu: issue fields, flush, stall and the EX/MEM result.
interface cpu_ex_mdu_if #(parameter int XLEN = 32, parameter int SHW = 5);
  logic            flush;
  logic            id_valid;
  logic [3:0]      id_op;
  logic [XLEN-1:0] id_a;
  logic [XLEN-1:0] id_b;
  logic [SHW-1:0]  id_shamt;
  logic [4:0]      id_rf_waddr;
  logic            id_c_rfw;
  logic            ex_stall;
  logic            p_valid;
  logic [XLEN-1:0] p_alu_r;
  logic [4:0]      p_rf_waddr;
  logic            p_c_rfw;
  logic            mdu_busy;

  modport master (
    output flush, id_valid, id_op, id_a, id_b, id_shamt, id_rf_waddr, id_c_rfw,
    input  ex_stall, p_valid, p_alu_r, p_rf_waddr, p_c_rfw, mdu_busy
  );
  modport slave (
    input  flush, id_valid, id_op, id_a, id_b, id_shamt, id_rf_waddr, id_c_rfw,
    output ex_stall, p_valid, p_alu_r, p_rf_waddr, p_c_rfw, mdu_busy
  );
endinterface

// File: rtl/cpu_ex_mdu.sv
// Execute stage: single-cycle ALU plus background shift-add / restoring-divide MDU with HI/LO.
// Optional build macro CPU_EX_MDU_EARLY_OUT_EN: multiply exits once the remaining multiplier bits are zero.
module cpu_ex_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input logic         clk,
  input logic         rst,
  cpu_ex_mdu_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
                         OP_NOR  = 4'h4, OP_SLT  = 4'h5, OP_SLTU = 4'h6, OP_SLL  = 4'h7,
                         OP_SRL  = 4'h8, OP_MULT = 4'h9, OP_MULTU= 4'hA, OP_DIV  = 4'hB,
                         OP_DIVU = 4'hC, OP_MFHI = 4'hD, OP_MFLO = 4'hE, OP_NOP  = 4'hF;

  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3;

  logic [1:0]        state;
  logic [SHW-1:0]    cnt;
  logic [XLEN-1:0]   hi, lo;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   qm;        // multiplier in MUL, dividend/quotient in DIV
  logic [XLEN-1:0]   rem, dvsr, dvd_orig;
  logic              neg_q, neg_r, div0, op_div;

  logic is_mdu, is_hilo, accept, mdu_start, op_signed, op_isdiv;
  logic a_neg, b_neg, last, mul_done, ge;
  logic [XLEN-1:0]   a_abs, b_abs, alu_r;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN:0]     r_sh;
  logic [XLEN+1:0]   diff;

  assign is_mdu    = (bus.id_op >= OP_MULT) && (bus.id_op <= OP_DIVU);
  assign is_hilo   = (bus.id_op == OP_MFHI) || (bus.id_op == OP_MFLO);
  assign bus.mdu_busy = (state != S_IDLE);
  assign bus.ex_stall = bus.id_valid & bus.mdu_busy & (is_mdu | is_hilo) & ~bus.flush;
  assign accept    = bus.id_valid & ~bus.ex_stall & ~bus.flush;
  assign mdu_start = accept & is_mdu;

  assign op_signed = (bus.id_op == OP_MULT) || (bus.id_op == OP_DIV);
  assign op_isdiv  = (bus.id_op == OP_DIV)  || (bus.id_op == OP_DIVU);
  assign a_neg     = op_signed & bus.id_a[XLEN-1];
  assign b_neg     = op_signed & bus.id_b[XLEN-1];
  assign a_abs     = a_neg ? -bus.id_a : bus.id_a;
  assign b_abs     = b_neg ? -bus.id_b : bus.id_b;

  assign last    = (cnt == SHW'(XLEN-1));
  assign acc_nxt = acc + (qm[0] ? mcand : '0);
  assign r_sh    = {rem, qm[XLEN-1]};
  assign diff    = {1'b0, r_sh} - {2'b00, dvsr};
  assign ge      = ~diff[XLEN+1];

`ifdef CPU_EX_MDU_EARLY_OUT_EN
  assign mul_done = last | (qm[XLEN-1:1] == '0);
`else
  assign mul_done = last;
`endif

  always_comb begin
    alu_r = '0;
    case (bus.id_op)
      OP_ADD:  alu_r = bus.id_a + bus.id_b;
      OP_SUB:  alu_r = bus.id_a - bus.id_b;
      OP_AND:  alu_r = bus.id_a & bus.id_b;
      OP_OR:   alu_r = bus.id_a | bus.id_b;
      OP_NOR:  alu_r = ~(bus.id_a | bus.id_b);
      OP_SLT:  alu_r[0] = $signed(bus.id_a) < $signed(bus.id_b);
      OP_SLTU: alu_r[0] = bus.id_a < bus.id_b;
      OP_SLL:  alu_r = bus.id_b << bus.id_shamt;
      OP_SRL:  alu_r = bus.id_b >> bus.id_shamt;
      OP_MFHI: alu_r = hi;
      OP_MFLO: alu_r = lo;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE; cnt <= '0; hi <= '0; lo <= '0;
      acc <= '0; mcand <= '0; qm <= '0; rem <= '0; dvsr <= '0; dvd_orig <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; div0 <= 1'b0; op_div <= 1'b0;
    end else if (bus.flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (mdu_start) begin
          acc      <= '0;
          rem      <= '0;
          mcand    <= {{XLEN{1'b0}}, a_abs};
          dvsr     <= b_abs;
          qm       <= op_isdiv ? a_abs : b_abs;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          div0     <= (bus.id_b == '0);
          dvd_orig <= bus.id_a;
          op_div   <= op_isdiv;
          cnt      <= '0;
          state    <= op_isdiv ? S_DIV : S_MUL;
        end
        S_MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          qm    <= qm >> 1;
          cnt   <= cnt + 1'b1;
          if (mul_done) state <= S_FIX;
        end
        S_DIV: begin
          rem <= ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
          qm  <= {qm[XLEN-2:0], ge};
          cnt <= cnt + 1'b1;
          if (last) state <= S_FIX;
        end
        default: begin
          // Divide-by-zero bypasses sign fixup so HI keeps the original signed dividend.
          if (!op_div) begin
            {hi, lo} <= neg_q ? -acc : acc;
          end else if (div0) begin
            lo <= '1;
            hi <= dvd_orig;
          end else begin
            lo <= neg_q ? -qm : qm;
            hi <= neg_r ? -rem : rem;
          end
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.p_valid <= 1'b0; bus.p_alu_r <= '0; bus.p_rf_waddr <= '0; bus.p_c_rfw <= 1'b0;
    end else if (bus.flush) begin
      bus.p_valid <= 1'b0;
      bus.p_c_rfw <= 1'b0;
    end else begin
      bus.p_valid <= accept;
      bus.p_c_rfw <= accept & bus.id_c_rfw & ~is_mdu & (bus.id_op != OP_NOP);
      if (accept) begin
        bus.p_alu_r    <= alu_r;
        bus.p_rf_waddr <= bus.id_rf_waddr;
      end
    end
  end
endmodule
